// File: rtl/data_router_arbiter.sv
// data_router_arbiter: round-robin sequencer for the shared 8-bit data RAM
// bus and data router. Serves word read, word write and read-modify-write
// single-bit write for NUM_CORES PLC cores, one transaction at a time.
module data_router_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                        CLK,
  input  logic                        RST_n,
  input  logic [NUM_CORES-1:0]        REQ,
  input  logic [NUM_CORES-1:0]        REQ_WE,
  input  logic [NUM_CORES-1:0]        REQ_BIT,
  input  logic [NUM_CORES*ADDR_W-1:0] REQ_ADDR,
  input  logic [NUM_CORES*8-1:0]      REQ_WDATA,
  input  logic [NUM_CORES*3-1:0]      REQ_BITSEL,
  input  logic [NUM_CORES-1:0]        REQ_BITVAL,
  output logic [NUM_CORES-1:0]        ACK,
  output logic [7:0]                  RDATA,
  output logic [ADDR_W-1:0]           RAM_ADDR,
  output logic                        RAM_CS,
  output logic                        RAM_WE,
  output logic                        ROUTER_WriteData,
  output logic                        ROUTER_Addr,
  output logic [7:0]                  ROUTER_WORDUNIT,
  output logic                        ROUTER_BITUNIT,
  input  logic [7:0]                  ROUTER_CPUData
);

  localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RDWAIT, S_WR, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                we_q, we_d, bit_q, bit_d, bitval_q, bitval_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d, data_q, data_d;
  logic [2:0]          bitsel_q, bitsel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt_vld;
  logic [PTR_W-1:0]    gnt_idx;
  logic                grant, rd_last;

  logic [NUM_CORES-1:0] ack_d;
  logic [7:0]           rdata_d, word_d, word_mod;
  logic [ADDR_W-1:0]    ram_addr_d;
  logic                 cs_d, ram_we_d, wd_d, raddr_d, bitu_d;

  assign grant   = (state_q == S_IDLE) && gnt_vld;
  assign rd_last = (state_q == S_RDWAIT) && (cnt_q == CNT_W'(RD_LAT - 1));

  // Round-robin search starting just after the last granted core
  always_comb begin
    int unsigned cand;
    cand    = 0;
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!gnt_vld && REQ[PTR_W'(cand)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(cand);
      end
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt_vld) state_d = (REQ_WE[gnt_idx] && !REQ_BIT[gnt_idx]) ? S_WR : S_RD;
      S_RD:     state_d = S_RDWAIT;
      S_RDWAIT: if (rd_last) state_d = (we_q && bit_q) ? S_WR : S_DONE;
      S_WR:     state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Command latch, read-wait counter and captured read word
  always_comb begin
    ptr_d    = ptr_q;
    we_d     = we_q;
    bit_d    = bit_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bitsel_d = bitsel_q;
    bitval_d = bitval_q;
    if (grant) begin
      ptr_d    = gnt_idx;
      we_d     = REQ_WE[gnt_idx];
      bit_d    = REQ_BIT[gnt_idx];
      addr_d   = REQ_ADDR[gnt_idx*ADDR_W +: ADDR_W];
      wdata_d  = REQ_WDATA[gnt_idx*8 +: 8];
      bitsel_d = REQ_BITSEL[gnt_idx*3 +: 3];
      bitval_d = REQ_BITVAL[gnt_idx];
    end
    cnt_d  = (state_q == S_RDWAIT) ? cnt_q + CNT_W'(1) : '0;
    data_d = rd_last ? ROUTER_CPUData : data_q;
  end

  // Output decode from the next state so registered outputs align with state_q
  always_comb begin
    ack_d      = '0;
    rdata_d    = '0;
    cs_d       = 1'b0;
    ram_we_d   = 1'b0;
    wd_d       = 1'b0;
    raddr_d    = 1'b0;
    bitu_d     = 1'b0;
    word_d     = '0;
    ram_addr_d = addr_d;
    word_mod   = data_d;
    word_mod[bitsel_d] = bitval_d;
    case (state_d)
      S_RD: cs_d = 1'b1;
      S_WR: begin
        cs_d     = 1'b1;
        ram_we_d = 1'b1;
        wd_d     = 1'b1;
        if (we_d && bit_d) begin
          word_d  = word_mod;
          raddr_d = (bitsel_d == 3'd0);
          bitu_d  = bitval_d;
        end else begin
          word_d  = wdata_d;
        end
      end
      S_DONE: begin
        ack_d[ptr_d] = 1'b1;
        rdata_d      = (we_d && !bit_d) ? 8'h00 : data_d;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      ptr_q            <= PTR_W'(NUM_CORES - 1);
      we_q             <= 1'b0;
      bit_q            <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      bitsel_q         <= '0;
      bitval_q         <= 1'b0;
      cnt_q            <= '0;
      data_q           <= '0;
      ACK              <= '0;
      RDATA            <= '0;
      RAM_ADDR         <= '0;
      RAM_CS           <= 1'b0;
      RAM_WE           <= 1'b0;
      ROUTER_WriteData <= 1'b0;
      ROUTER_Addr      <= 1'b0;
      ROUTER_WORDUNIT  <= '0;
      ROUTER_BITUNIT   <= 1'b0;
    end else begin
      ptr_q            <= ptr_d;
      we_q             <= we_d;
      bit_q            <= bit_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      bitsel_q         <= bitsel_d;
      bitval_q         <= bitval_d;
      cnt_q            <= cnt_d;
      data_q           <= data_d;
      ACK              <= ack_d;
      RDATA            <= rdata_d;
      RAM_ADDR         <= ram_addr_d;
      RAM_CS           <= cs_d;
      RAM_WE           <= ram_we_d;
      ROUTER_WriteData <= wd_d;
      ROUTER_Addr      <= raddr_d;
      ROUTER_WORDUNIT  <= word_d;
      ROUTER_BITUNIT   <= bitu_d;
    end
  end

endmodule

// File: tb/tb_data_router_arbiter.sv
// Bench for data_router_arbiter: RAM + router model, ACK scoreboard.
module tb_data_router_arbiter;

  localparam int unsigned NC = 4;
  localparam int unsigned AW = 10;

  logic              CLK, RST_n;
  logic [NC-1:0]     REQ, REQ_WE, REQ_BIT, REQ_BITVAL;
  logic [NC*AW-1:0]  REQ_ADDR;
  logic [NC*8-1:0]   REQ_WDATA;
  logic [NC*3-1:0]   REQ_BITSEL;
  logic [NC-1:0]     ACK;
  logic [7:0]        RDATA, ROUTER_WORDUNIT, ROUTER_CPUData;
  logic [AW-1:0]     RAM_ADDR;
  logic              RAM_CS, RAM_WE, ROUTER_WriteData, ROUTER_Addr, ROUTER_BITUNIT;

  data_router_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .RD_LAT(1)) dut (
    .CLK(CLK), .RST_n(RST_n), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_BIT(REQ_BIT),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_BITSEL(REQ_BITSEL),
    .REQ_BITVAL(REQ_BITVAL), .ACK(ACK), .RDATA(RDATA), .RAM_ADDR(RAM_ADDR),
    .RAM_CS(RAM_CS), .RAM_WE(RAM_WE), .ROUTER_WriteData(ROUTER_WriteData),
    .ROUTER_Addr(ROUTER_Addr), .ROUTER_WORDUNIT(ROUTER_WORDUNIT),
    .ROUTER_BITUNIT(ROUTER_BITUNIT), .ROUTER_CPUData(ROUTER_CPUData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM + router model: router drives BITUNIT onto bit 0 when ROUTER_Addr=1
  logic [7:0]    mem [0:(1<<AW)-1];
  logic [7:0]    rd_q;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;
  wire  [7:0]    bus_w = ROUTER_Addr ? {ROUTER_WORDUNIT[7:1], ROUTER_BITUNIT} : ROUTER_WORDUNIT;
  assign ROUTER_CPUData = rd_q;

  always @(posedge CLK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (RAM_CS && RAM_WE) mem[RAM_ADDR] <= bus_w;
    if (RAM_CS && !RAM_WE) rd_q <= mem[RAM_ADDR];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0] core;
    logic [7:0] data;
  } sb_t;
  sb_t sb_q[$];

  int we_cnt  = 0;
  int wd_viol = 0;

  // ACK scoreboard plus bus-direction monitor
  always @(negedge CLK) begin
    sb_t e;
    logic [NC-1:0] ack_exp;
    if (RAM_CS && RAM_WE) we_cnt++;
    if (ROUTER_WriteData != (RAM_CS && RAM_WE)) wd_viol++;
    if (|ACK) begin
      if (sb_q.size() == 0) begin
        check_eq("ack_unexpected", 32'(ACK), 32'h0);
      end else begin
        e = sb_q.pop_front();
        ack_exp = '0;
        ack_exp[e.core] = 1'b1;
        check_eq("ack_core", 32'(ACK), 32'(ack_exp));
        check_eq("ack_rdata", 32'(RDATA), 32'(e.data));
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge CLK);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge CLK);
    pl_en = 1'b0;
  endtask

  task automatic set_cmd(input int c, input logic we, input logic b, input logic [AW-1:0] a,
                         input logic [7:0] wd, input logic [2:0] bs, input logic bv);
    REQ_WE[c] = we; REQ_BIT[c] = b; REQ_ADDR[c*AW +: AW] = a;
    REQ_WDATA[c*8 +: 8] = wd; REQ_BITSEL[c*3 +: 3] = bs; REQ_BITVAL[c] = bv;
  endtask

  // Single transaction from an idle DUT; checks latency and bus activity
  task automatic run_txn(input string tag, input int c, input logic we, input logic b,
                         input logic [AW-1:0] a, input logic [7:0] wd, input logic [2:0] bs,
                         input logic bv, input logic [7:0] exp_rd, input int exp_lat,
                         input logic [7:0] exp_word, input logic exp_raddr);
    int  lat, nrd, nwr;
    logic got;
    sb_t e;
    set_cmd(c, we, b, a, wd, bs, bv);
    e.core = 3'(c); e.data = exp_rd;
    sb_q.push_back(e);
    REQ[c] = 1'b1;
    lat = 0; nrd = 0; nwr = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge CLK);
      lat++;
      if (RAM_CS) check_eq({tag, "_addr"}, 32'(RAM_ADDR), 32'(a));
      if (RAM_CS && !RAM_WE) nrd++;
      if (RAM_CS && RAM_WE) begin
        nwr++;
        check_eq({tag, "_word"}, 32'(ROUTER_WORDUNIT), 32'(exp_word));
        check_eq({tag, "_raddr"}, 32'(ROUTER_Addr), 32'(exp_raddr));
        if (b) check_eq({tag, "_bitunit"}, 32'(ROUTER_BITUNIT), 32'(bv));
      end
      if (ACK[c]) got = 1'b1;
    end
    REQ[c] = 1'b0;
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_nrd"}, 32'(nrd), (we && !b) ? 32'd0 : 32'd1);
    check_eq({tag, "_nwr"}, 32'(nwr), we ? 32'd1 : 32'd0);
    @(negedge CLK);
  endtask

  // Collect up to n ACKs from multiple held requests, dropping REQ on ACK
  task automatic collect(input int n, input logic reraise1, output int cnt, output int ord [8]);
    logic done1, pend;
    cnt = 0; done1 = 1'b0; pend = 1'b0;
    for (int k = 0; k < 8; k++) ord[k] = -1;
    for (int t = 0; t < 200 && cnt < n; t++) begin
      @(negedge CLK);
      if (pend) begin REQ[1] = 1'b1; pend = 1'b0; end
      for (int k = 0; k < int'(NC); k++) begin
        if (ACK[k]) begin
          if (cnt < 8) ord[cnt] = k;
          cnt++;
          REQ[k] = 1'b0;
          if (k == 1 && reraise1 && !done1) begin done1 = 1'b1; pend = 1'b1; end
        end
      end
    end
  endtask

  initial begin
    int   cnt;
    int   ord [8];
    int   exp_ord [5];
    int   we0;
    logic [7:0] v, w;
    logic [2:0] bs;
    logic bv;
    sb_t  e;

    RST_n = 1'b0; REQ = '0; REQ_WE = '0; REQ_BIT = '0; REQ_BITVAL = '0;
    REQ_ADDR = '0; REQ_WDATA = '0; REQ_BITSEL = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    preload(10'h005, 8'hA7);
    preload(10'h020, 8'h81);
    preload(10'h021, 8'hFF);
    preload(10'h030, 8'h55);
    for (int k = 0; k < 4; k++) preload(10'(10'h040 + k), 8'(8'hC0 + k));

    check_eq("rst_ack", 32'(ACK), 32'h0);
    check_eq("rst_rdata", 32'(RDATA), 32'h0);
    check_eq("rst_cs", 32'(RAM_CS), 32'h0);
    check_eq("rst_we", 32'(RAM_WE), 32'h0);
    check_eq("rst_wd", 32'(ROUTER_WriteData), 32'h0);
    check_eq("rst_word", 32'(ROUTER_WORDUNIT), 32'h0);
    check_eq("rst_raddr", 32'(RAM_ADDR), 32'h0);

    RST_n = 1'b1;
    @(negedge CLK);

    run_txn("rd",  2, 1'b0, 1'b0, 10'h005, 8'h00, 3'd0, 1'b0, 8'hA7, 3, 8'h00, 1'b0);
    run_txn("wr",  1, 1'b1, 1'b0, 10'h010, 8'h3C, 3'd0, 1'b0, 8'h00, 2, 8'h3C, 1'b0);
    check_eq("wr_mem", 32'(mem[10'h010]), 32'h3C);
    run_txn("rb",  1, 1'b0, 1'b0, 10'h010, 8'h00, 3'd0, 1'b0, 8'h3C, 3, 8'h00, 1'b0);
    run_txn("bw3", 0, 1'b1, 1'b1, 10'h020, 8'h00, 3'd3, 1'b1, 8'h81, 4, 8'h89, 1'b0);
    check_eq("bw3_mem", 32'(mem[10'h020]), 32'h89);
    run_txn("bw0", 3, 1'b1, 1'b1, 10'h021, 8'h00, 3'd0, 1'b0, 8'hFF, 4, 8'hFE, 1'b1);
    check_eq("bw0_mem", 32'(mem[10'h021]), 32'hFE);

    for (int i = 0; i < 4; i++) begin
      v  = 8'($urandom_range(0, 255));
      bs = 3'($urandom_range(0, 7));
      bv = 1'($urandom_range(0, 1));
      w  = v;
      w[bs] = bv;
      preload(10'(10'h050 + i), v);
      run_txn("bwr", i, 1'b1, 1'b1, 10'(10'h050 + i), 8'h00, bs, bv, v, 4, w, bs == 3'd0);
      check_eq("bwr_mem", 32'(mem[10'(10'h050 + i)]), 32'(w));
    end

    // Round-robin: all cores request out of reset; core 1 re-requests later
    RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 4; k++) set_cmd(k, 1'b0, 1'b0, 10'(10'h040 + k), 8'h00, 3'd0, 1'b0);
    exp_ord = '{0, 1, 2, 3, 1};
    for (int k = 0; k < 5; k++) begin
      e.core = 3'(exp_ord[k]); e.data = 8'(8'hC0 + exp_ord[k]);
      sb_q.push_back(e);
    end
    REQ = 4'hF;
    RST_n = 1'b1;
    collect(5, 1'b1, cnt, ord);
    check_eq("rr_count", 32'(cnt), 32'd5);
    for (int k = 0; k < 5; k++) check_eq("rr_order", 32'(ord[k]), 32'(exp_ord[k]));
    @(negedge CLK);

    // Reset during the read-wait of a bit write
    set_cmd(2, 1'b1, 1'b1, 10'h030, 8'h00, 3'd1, 1'b1);
    REQ[2] = 1'b1;
    @(negedge CLK);
    check_eq("mo_rd_cs", 32'(RAM_CS), 32'h1);
    @(negedge CLK);
    we0 = we_cnt;
    RST_n = 1'b0;
    REQ[2] = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      check_eq("mo_cs", 32'(RAM_CS), 32'h0);
      check_eq("mo_we", 32'(RAM_WE), 32'h0);
      check_eq("mo_wd", 32'(ROUTER_WriteData), 32'h0);
    end
    check_eq("mo_we_pulses", 32'(we_cnt - we0), 32'd0);
    check_eq("mo_mem", 32'(mem[10'h030]), 32'h55);
    set_cmd(0, 1'b0, 1'b0, 10'h040, 8'h00, 3'd0, 1'b0);
    set_cmd(3, 1'b0, 1'b0, 10'h043, 8'h00, 3'd0, 1'b0);
    e.core = 3'd0; e.data = 8'hC0; sb_q.push_back(e);
    e.core = 3'd3; e.data = 8'hC3; sb_q.push_back(e);
    REQ = 4'b1001;
    RST_n = 1'b1;
    collect(2, 1'b0, cnt, ord);
    check_eq("mo_count", 32'(cnt), 32'd2);
    check_eq("mo_first", 32'(ord[0]), 32'd0);
    check_eq("mo_second", 32'(ord[1]), 32'd3);

    repeat (3) @(negedge CLK);
    check_eq("wd_only_in_wr", 32'(wd_viol), 32'd0);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
